// File: rtl/tug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tug_pkg : shared round-state encoding for the tug-of-war playfield   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        HOLD    = 2'd1,
        RESTART = 2'd2,
        DONE    = 2'd3
    } round_state_t;

endpackage
`default_nettype wire

// File: rtl/tug_round_ctrl_press_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | press_pulse : one-cycle rising-edge detect on a synchronised button  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module press_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic key_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign press = key & ~key_q;

endmodule
`default_nettype wire

// File: rtl/tug_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tug_round_ctrl : round/match sequencer for the tug-of-war playfield  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tug_round_ctrl
    import tug_pkg::*;
#(
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_l,
    input  logic               key_r,
    input  logic               edge_l_on,
    input  logic               edge_r_on,
    output logic               L,
    output logic               R,
    output logic               resetRound,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner_r
);

    localparam int                 CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    round_state_t       state, state_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [SCORE_W-1:0] score_l_nxt, score_r_nxt;
    logic               winner_r_nxt, l_nxt, r_nxt;
    logic               press_l, press_r, point_l, point_r;

    press_pulse u_press_l (.clk(clk), .reset(reset), .key(key_l), .press(press_l));
    press_pulse u_press_r (.clk(clk), .reset(reset), .key(key_r), .press(press_r));

    // Simultaneous presses cancel out: only a lone push off the edge scores.
    assign point_l = press_l & ~press_r & edge_l_on;
    assign point_r = press_r & ~press_l & edge_r_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PLAY;
            hold_cnt <= '0;
            score_l  <= '0;
            score_r  <= '0;
            winner_r <= 1'b0;
            L        <= 1'b0;
            R        <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            score_l  <= score_l_nxt;
            score_r  <= score_r_nxt;
            winner_r <= winner_r_nxt;
            L        <= l_nxt;
            R        <= r_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        score_l_nxt  = score_l;
        score_r_nxt  = score_r;
        winner_r_nxt = winner_r;
        l_nxt        = 1'b0;
        r_nxt        = 1'b0;
        case (state)
            PLAY: begin
                if (point_l || point_r) begin
                    hold_cnt_nxt = HOLD_LOAD;
                    if (point_l) begin
                        score_l_nxt = score_l + 1'b1;
                    end else begin
                        score_r_nxt = score_r + 1'b1;
                    end
                    // Reaching the winning score ends the match, so scores never wrap.
                    if ((point_l && score_l_nxt == WIN_VAL) ||
                        (point_r && score_r_nxt == WIN_VAL)) begin
                        state_nxt    = DONE;
                        winner_r_nxt = point_r;
                    end else begin
                        state_nxt = HOLD;
                    end
                end else begin
                    l_nxt = press_l;
                    r_nxt = press_r;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = RESTART;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end
            RESTART: state_nxt = PLAY;
            DONE:    state_nxt = DONE;
            default: state_nxt = PLAY;
        endcase
    end

    assign resetRound = (state == RESTART);
    assign game_over  = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_tug_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tug_round_ctrl : directed bench, WIN_SCORE=3, HOLD_CYCLES=4       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tug_round_ctrl;

    logic       clk = 1'b0;
    logic       reset, key_l, key_r, edge_l_on, edge_r_on;
    logic       L, R, resetRound, game_over, winner_r;
    logic [2:0] score_l, score_r;
    int         n_cmp = 0;
    int         n_err = 0;

    tug_round_ctrl #(.SCORE_W(3), .WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
        .edge_l_on(edge_l_on), .edge_r_on(edge_r_on),
        .L(L), .R(R), .resetRound(resetRound),
        .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner_r(winner_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic right_point();
        edge_r_on = 1'b1;
        key_r     = 1'b1;
        tick();
        key_r     = 1'b0;
        edge_r_on = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_l = 1'b0; key_r = 1'b0; edge_l_on = 1'b0; edge_r_on = 1'b0;
        tick(); tick();
        chk("rst_outs", {L, R, resetRound, game_over, winner_r}, 5'b0);
        chk("rst_scores", {score_l, score_r}, 6'd0);
        reset = 1'b0;
        tick();

        // 1: held key gives one L pulse, one cycle after rise
        key_l = 1'b1;
        chk("s1_pre", L, 1'b0);
        tick();
        chk("s1_pulse", {L, R}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1_held", L, 1'b0);
        end
        key_l = 1'b0;
        tick();

        // 2: left point, hold for 4 cycles, restart, back to play
        edge_l_on = 1'b1;
        key_l     = 1'b1;
        tick();
        chk("s2_score", {score_l, score_r}, {3'd1, 3'd0});
        chk("s2_nopulse", {L, R, resetRound}, 3'b000);
        key_l = 1'b0;
        tick();
        chk("s2_hold2", resetRound, 1'b0);
        key_l = 1'b1;
        key_r = 1'b1;
        tick();
        chk("s2_hold_press", {L, R, resetRound}, 3'b000);
        chk("s2_hold_score", {score_l, score_r}, {3'd1, 3'd0});
        key_l = 1'b0;
        key_r = 1'b0;
        tick();
        chk("s2_hold4", {L, R, resetRound}, 3'b000);
        tick();
        chk("s2_restart", resetRound, 1'b1);
        key_r = 1'b1;
        tick();
        chk("s2_after_rr", {R, resetRound}, 2'b00);
        key_r     = 1'b0;
        edge_l_on = 1'b0;
        tick();
        key_l = 1'b1;
        tick();
        chk("s2_play_again", {L, R}, 2'b10);
        key_l = 1'b0;
        tick();

        // 3: simultaneous presses with edge lit never score
        edge_r_on = 1'b1;
        key_l     = 1'b1;
        key_r     = 1'b1;
        tick();
        chk("s3_both", {L, R}, 2'b11);
        chk("s3_score", {score_l, score_r}, {3'd1, 3'd0});
        tick();
        chk("s3_end", {L, R}, 2'b00);
        key_l = 1'b0; key_r = 1'b0; edge_r_on = 1'b0;
        tick();

        // 4: right player wins 3-0
        reset = 1'b1;
        #1;
        chk("s4_rst", {score_l, score_r}, 6'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int p = 1; p <= 2; p++) begin
            right_point();
            chk("s4_score", {score_r, game_over}, {3'(p), 1'b0});
            for (int i = 0; i < 5; i++) tick();
        end
        right_point();
        chk("s4_win", {score_r, game_over, winner_r, R}, {3'd3, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s4_no_rr", resetRound, 1'b0);
        end
        key_l = 1'b1;
        key_r = 1'b1;
        tick();
        chk("s4_done_press", {L, R, resetRound, game_over}, 4'b0001);
        chk("s4_frozen", {score_l, score_r}, {3'd0, 3'd3});
        key_l = 1'b0;
        key_r = 1'b0;
        tick();

        // 5: reset in the middle of HOLD
        reset = 1'b1;
        #1;
        chk("s5_rst_done", game_over, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        edge_l_on = 1'b1;
        key_l     = 1'b1;
        tick();
        chk("s5_point", score_l, 3'd1);
        key_l     = 1'b0;
        edge_l_on = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("s5_async", {score_l, resetRound, game_over}, 5'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s5_no_rr", resetRound, 1'b0);
        end
        key_l = 1'b1;
        tick();
        chk("s5_pulse", {L, R}, 2'b10);
        tick();
        chk("s5_pulse_end", L, 1'b0);
        key_l = 1'b0;
        tick();

        // 6: lit edge without a press does nothing
        edge_l_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s6_idle", {L, R, resetRound, score_l, score_r}, 9'd0);
        end
        edge_l_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
